// File: rtl/alarm_controller.sv
// alarm_controller: intruder-alarm FSM with exit/entry grace, timed siren, keypad disarm and wrong-code lockout
module alarm_controller #(
  parameter int          EXIT_CYCLES  = 10,
  parameter int          ENTRY_CYCLES = 10,
  parameter int          ALARM_CYCLES = 50,
  parameter logic [3:0]  SECRET_CODE  = 4'hA,
  parameter int          MAX_TRIES    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm_req,
  input  logic       code_valid,
  input  logic [3:0] code_in,
  input  logic       sensor_door,
  input  logic       sensor_motion,
  output logic       siren_en,
  output logic       armed_led,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;
  localparam int MAXC = (EXIT_CYCLES > ENTRY_CYCLES)
                        ? ((EXIT_CYCLES > ALARM_CYCLES) ? EXIT_CYCLES : ALARM_CYCLES)
                        : ((ENTRY_CYCLES > ALARM_CYCLES) ? ENTRY_CYCLES : ALARM_CYCLES);
  localparam int TW = $clog2(MAXC + 1);
  localparam int CW = $clog2(MAX_TRIES + 1);
  state_t          r_state, w_next;
  logic [TW-1:0]   r_timer, w_timer, w_load;
  logic [CW-1:0]   r_wrong, w_wrong;
  logic            w_ok, w_bad, w_expired;
  assign w_ok      = code_valid && (code_in == SECRET_CODE);
  assign w_bad     = code_valid && (code_in != SECRET_CODE);
  assign w_expired = (r_timer == '0);
  always_comb begin
    w_next  = r_state;
    w_wrong = r_wrong;
    case (r_state)
      S_DISARMED: w_next = arm_req ? S_EXIT : S_DISARMED;
      S_EXIT, S_ARMED, S_ENTRY: begin
        if (w_ok) begin
          w_next  = S_DISARMED;
          w_wrong = '0;
        end else if (w_bad && r_wrong == CW'(MAX_TRIES - 1)) begin
          w_next  = S_ALARM;
          w_wrong = '0;
        end else begin
          w_wrong = w_bad ? r_wrong + CW'(1) : r_wrong;
          if (r_state == S_ARMED)
            w_next = sensor_motion ? S_ALARM : sensor_door ? S_ENTRY : S_ARMED;
          else if (w_expired)
            w_next = (r_state == S_EXIT) ? S_ARMED : S_ALARM;
        end
      end
      S_ALARM: begin
        if (w_ok) begin
          w_next  = S_DISARMED;
          w_wrong = '0;
        end else if (w_expired) begin
          w_next = S_ARMED;
        end
      end
      default: w_next = S_DISARMED;
    endcase
  end
  // Timer reloads on every state change so each timed state dwells exactly its *_CYCLES
  always_comb begin
    w_load  = w_next == S_EXIT  ? TW'(EXIT_CYCLES - 1)
            : w_next == S_ENTRY ? TW'(ENTRY_CYCLES - 1)
            : w_next == S_ALARM ? TW'(ALARM_CYCLES - 1)
            : '0;
    w_timer = (w_next != r_state) ? w_load
            : (r_timer != '0)     ? r_timer - TW'(1)
            : r_timer;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_DISARMED;
      r_timer   <= '0;
      r_wrong   <= '0;
      siren_en  <= 1'b0;
      armed_led <= 1'b0;
      state_o   <= 3'd0;
    end else begin
      r_state   <= w_next;
      r_timer   <= w_timer;
      r_wrong   <= w_wrong;
      siren_en  <= (w_next == S_ALARM);
      armed_led <= (w_next == S_ARMED) || (w_next == S_ENTRY) || (w_next == S_ALARM);
      state_o   <= w_next;
    end
  end
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed and random stimulus scored against a dwell-counting reference model
module tb_alarm_controller;
  logic       clk = 1'b0;
  logic       rst, arm_req, code_valid, sensor_door, sensor_motion;
  logic [3:0] code_in;
  logic       siren_en, armed_led;
  logic [2:0] state_o;
  alarm_controller dut (
    .clk(clk), .rst(rst), .arm_req(arm_req), .code_valid(code_valid), .code_in(code_in),
    .sensor_door(sensor_door), .sensor_motion(sensor_motion),
    .siren_en(siren_en), .armed_led(armed_led), .state_o(state_o)
  );
  always #5 clk = ~clk;
  typedef struct {int st; int sir; int led; int cyc;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0, cyc = 0;
  int m_st = 0, m_left = 0, m_wrong = 0;
  task automatic chk(string nm, int c, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, c, got, exp);
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("state_o", e.cyc, int'(state_o), e.st);
      chk("siren_en", e.cyc, int'(siren_en), e.sir);
      chk("armed_led", e.cyc, int'(armed_led), e.led);
    end
  end
  function automatic int dwell(int s);
    return s == 1 ? 10 : s == 3 ? 10 : s == 4 ? 50 : 0;
  endfunction
  // Reference: m_left counts the cycles still to be spent in the current timed state
  task automatic model();
    int  nst;
    bit  ok, bad;
    if (rst) begin
      m_st = 0; m_left = 0; m_wrong = 0;
      return;
    end
    ok  = code_valid && code_in == 4'hA;
    bad = code_valid && code_in != 4'hA;
    nst = m_st;
    if (m_st == 0) begin
      if (arm_req) nst = 1;
    end else if (ok) begin
      nst = 0; m_wrong = 0;
    end else if (m_st != 4 && bad && m_wrong + 1 >= 3) begin
      nst = 4; m_wrong = 0;
    end else begin
      if (m_st != 4 && bad) m_wrong++;
      if (m_st == 2) nst = sensor_motion ? 4 : sensor_door ? 3 : 2;
      else if (m_left == 1) nst = (m_st == 3) ? 4 : 2;
    end
    if (nst != m_st) m_left = dwell(nst);
    else if (m_left > 0) m_left--;
    m_st = nst;
  endtask
  task automatic step(bit r, bit a, bit cv, logic [3:0] code, bit door, bit mot);
    exp_t e;
    @(negedge clk);
    rst = r; arm_req = a; code_valid = cv; code_in = code; sensor_door = door; sensor_motion = mot;
    @(posedge clk);
    cyc++;
    model();
    e.st = m_st; e.sir = (m_st == 4); e.led = (m_st >= 2 && m_st <= 4); e.cyc = cyc;
    q.push_back(e);
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 4'h0, 0, 0);
  endtask
  initial begin
    rst = 1; arm_req = 0; code_valid = 0; code_in = 0; sensor_door = 0; sensor_motion = 0;
    step(1, 0, 0, 4'h0, 0, 0);
    step(1, 1, 1, 4'h3, 1, 1);
    idle(2);
    step(0, 1, 0, 4'h0, 0, 0);
    idle(12);
    step(0, 0, 0, 4'h0, 1, 0);
    idle(62);
    step(0, 0, 0, 4'h0, 1, 0);
    idle(3);
    step(0, 0, 1, 4'hA, 0, 0);
    idle(2);
    step(0, 1, 0, 4'h0, 0, 0);
    idle(11);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 4'h3, 0, 0);
      idle(2);
    end
    step(0, 0, 1, 4'h3, 0, 0);
    step(0, 0, 1, 4'hA, 0, 0);
    step(0, 1, 0, 4'h0, 0, 0);
    idle(11);
    step(0, 0, 0, 4'h0, 1, 1);
    idle(3);
    step(0, 0, 1, 4'hA, 0, 1);
    step(0, 1, 0, 4'h0, 0, 0);
    idle(11);
    step(0, 0, 1, 4'hA, 0, 1);
    step(0, 1, 1, 4'hA, 0, 0);
    idle(11);
    step(0, 0, 0, 4'h0, 0, 1);
    idle(5);
    step(1, 0, 0, 4'h0, 0, 0);
    idle(4);
    step(0, 1, 0, 4'h0, 0, 0);
    idle(11);
    for (int i = 0; i < 3000; i++) begin
      bit cv;
      logic [3:0] code;
      cv   = ($urandom_range(0, 9) == 0);
      code = $urandom_range(0, 1) ? 4'hA : 4'($urandom_range(0, 15));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, cv, code,
           $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
